// File: rtl/puf_array_eval_ctrl_pkg.sv
// Shared types and width helpers for the PUF array evaluation controller.
package puf_pkg;

    localparam int unsigned N_PUF_DEF  = 16;
    localparam int unsigned CHAL_W_DEF = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_FIRE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Bits needed to count 0..n (inclusive), used for the per-bit tally.
    function automatic int unsigned tally_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/puf_array_eval_ctrl_if.sv
// Host-side request/response bundle of the PUF array evaluation controller.
interface puf_array_eval_ctrl_if #(
    parameter int unsigned N_PUF  = 16,
    parameter int unsigned CHAL_W = 128
);
    logic              start;
    logic [CHAL_W-1:0] challenge;
    logic              busy;
    logic              done;
    logic [N_PUF-1:0]  response;
    logic [N_PUF-1:0]  unstable;

    modport master (
        output start, challenge,
        input  busy, done, response, unstable
    );

    modport slave (
        input  start, challenge,
        output busy, done, response, unstable
    );
endinterface

// File: rtl/puf_array_eval_ctrl_vote_counter.sv
// One response bit: 2-flop synchroniser, running tally and majority/instability decision.
module puf_vote_counter
    import puf_pkg::*;
#(
    parameter int unsigned N_EVAL = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic clear,
    input  logic sample_en,
    input  logic vote_en,
    output logic response,
    output logic unstable
);
    localparam int unsigned TALLY_W = tally_w(N_EVAL);

    logic [1:0]         sync;
    logic [TALLY_W-1:0] tally;
    logic [TALLY_W-1:0] tally_nxt;

    // Synchronise the asynchronous arbiter output; contents only matter in SAMPLE.
    always_ff @(posedge clk) begin
        sync <= {sync[0], raw};
    end

    // Tally including the current sample, so the vote can be registered on the last SAMPLE edge.
    always_comb begin
        tally_nxt = tally;
        if (sample_en && sync[1]) begin
            tally_nxt = tally + TALLY_W'(1);
        end
    end

    // Tally accumulation and registered vote outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            tally    <= '0;
            response <= 1'b0;
            unstable <= 1'b0;
        end else begin
            if (clear) begin
                tally <= '0;
            end else begin
                tally <= tally_nxt;
            end
            if (vote_en) begin
                response <= (tally_nxt > TALLY_W'(N_EVAL / 2));
                unstable <= (tally_nxt != '0) && (tally_nxt != TALLY_W'(N_EVAL));
            end
        end
    end

endmodule

// File: rtl/puf_array_eval_ctrl.sv
// Evaluation controller for an array of PDL arbiter PUFs: repeated reset/trigger/sample
// rounds on one latched challenge, with per-bit majority vote and instability flag.
module puf_array_eval_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned N_PUF      = N_PUF_DEF,
    parameter int unsigned CHAL_W     = CHAL_W_DEF,
    parameter int unsigned N_EVAL     = 7,
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    puf_array_eval_ctrl_if.slave host,
    output logic [CHAL_W-1:0]    puf_challenge,
    output logic                 puf_trigger,
    output logic                 puf_reset,
    input  logic [N_PUF-1:0]     puf_resp_raw
);
    localparam int unsigned EVAL_W  = cnt_w(N_EVAL);
    localparam int unsigned TIMER_W = cnt_w((RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC);

    state_t             state;
    state_t             state_nxt;
    logic [EVAL_W-1:0]  eval_cnt;
    logic [TIMER_W-1:0] timer;
    logic               last_round;
    logic               accept;
    logic               sample_en;
    logic               vote_en;
    logic               busy_nxt;
    logic               done_nxt;
    logic               trig_nxt;
    logic               prst_nxt;

    assign last_round = (eval_cnt == EVAL_W'(N_EVAL - 1));
    assign accept     = (state == S_IDLE) && host.start;
    assign sample_en  = (state == S_SAMPLE);
    assign vote_en    = sample_en && last_round;

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (host.start) state_nxt = S_PRST;
            S_PRST:   if (timer == TIMER_W'(RST_CYC - 1)) state_nxt = S_FIRE;
            S_FIRE:   if (timer == TIMER_W'(SETTLE_CYC - 1)) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last_round ? S_DONE : S_PRST;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        trig_nxt = (state_nxt == S_FIRE) || (state_nxt == S_SAMPLE);
        prst_nxt = !trig_nxt;
    end

    // State register, round/timing counters, challenge latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            eval_cnt      <= '0;
            puf_challenge <= '0;
            host.busy     <= 1'b0;
            host.done     <= 1'b0;
            puf_trigger   <= 1'b0;
            puf_reset     <= 1'b1;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt != state) ? '0 : timer + TIMER_W'(1);
            if (accept) begin
                puf_challenge <= host.challenge;
                eval_cnt      <= '0;
            end else if (sample_en && !last_round) begin
                eval_cnt <= eval_cnt + EVAL_W'(1);
            end
            host.busy   <= busy_nxt;
            host.done   <= done_nxt;
            puf_trigger <= trig_nxt;
            puf_reset   <= prst_nxt;
        end
    end

    for (genvar i = 0; i < N_PUF; i++) begin : g_bit
        puf_vote_counter #(.N_EVAL(N_EVAL)) u_vote (
            .clk       (clk),
            .reset     (reset),
            .raw       (puf_resp_raw[i]),
            .clear     (accept),
            .sample_en (sample_en),
            .vote_en   (vote_en),
            .response  (host.response[i]),
            .unstable  (host.unstable[i])
        );
    end

endmodule

// File: tb/tb_puf_array_eval_ctrl.sv
// Self-checking bench: randomized round patterns against a per-bit vote-count model,
// plus directed reset, busy-start, abort and single-round cases.
module tb_puf_array_eval_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  raw0, raw1;
    logic [127:0] pch0, pch1;
    logic         trig0, trig1, prst0, prst1;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] pat [7];

    always #5 clk = ~clk;

    puf_array_eval_ctrl_if #(.N_PUF(16), .CHAL_W(128)) if0 ();
    puf_array_eval_ctrl_if #(.N_PUF(16), .CHAL_W(128)) if1 ();

    puf_array_eval_ctrl #(
        .N_PUF(16), .CHAL_W(128), .N_EVAL(7), .RST_CYC(4), .SETTLE_CYC(8)
    ) dut0 (
        .clk(clk), .reset(rst), .host(if0.slave),
        .puf_challenge(pch0), .puf_trigger(trig0), .puf_reset(prst0), .puf_resp_raw(raw0)
    );

    puf_array_eval_ctrl #(
        .N_PUF(16), .CHAL_W(128), .N_EVAL(1), .RST_CYC(1), .SETTLE_CYC(3)
    ) dut1 (
        .clk(clk), .reset(rst), .host(if1.slave),
        .puf_challenge(pch1), .puf_trigger(trig1), .puf_reset(prst1), .puf_resp_raw(raw1)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Majority and disagreement per bit from the ones count over all rounds.
    task automatic model(output logic [15:0] er, output logic [15:0] eu);
        for (int b = 0; b < 16; b++) begin
            int ones = 0;
            for (int r = 0; r < 7; r++) ones += int'(pat[r][b]);
            er[b] = (ones > 3);
            eu[b] = (ones > 0) && (ones < 7);
        end
    endtask

    task automatic rand_pat();
        for (int r = 0; r < 7; r++) pat[r] = 16'($urandom);
    endtask

    // One request on the default instance; cycle k is observed 1 time unit after the k-th edge
    // counted from the edge that accepts start.
    task automatic run_req0(input logic [127:0] chal, input int intrude_at, input int abort_at,
                            input bit fixed_chk, input logic [15:0] fr, input logic [15:0] fu);
        logic [15:0] er, eu;
        model(er, eu);
        raw0          = pat[0];
        if0.challenge = chal;
        if0.start     = 1'b1;
        @(posedge clk); #1;
        if0.start     = 1'b0;
        if0.challenge = ~chal;
        for (int k = 1; k <= 94; k++) begin
            int p = (k - 1) % 13;
            if (k <= 91) begin
                check_eq("puf_reset", 128'(prst0), 128'(p < 4));
                check_eq("puf_trigger", 128'(trig0), 128'(p >= 4));
            end else begin
                check_eq("puf_reset_end", 128'(prst0), 128'(1));
                check_eq("puf_trigger_end", 128'(trig0), 128'(0));
            end
            check_eq("done", 128'(if0.done), 128'(k == 92));
            check_eq("busy", 128'(if0.busy), 128'(k <= 92));
            check_eq("puf_challenge", pch0, chal);
            if (k == 92) begin
                check_eq("response", 128'(if0.response), 128'(er));
                check_eq("unstable", 128'(if0.unstable), 128'(eu));
                if (fixed_chk) begin
                    check_eq("response_fixed", 128'(if0.response), 128'(fr));
                    check_eq("unstable_fixed", 128'(if0.unstable), 128'(fu));
                end
            end
            if ((k % 13 == 0) && (k < 91)) raw0 = pat[k / 13];
            if (k == intrude_at) begin
                if0.start     = 1'b1;
                if0.challenge = chal ^ 128'hFFFF_0000_FFFF_0000;
            end else begin
                if0.start = 1'b0;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_eq("abort_busy", 128'(if0.busy), 128'(0));
                check_eq("abort_done", 128'(if0.done), 128'(0));
                check_eq("abort_trigger", 128'(trig0), 128'(0));
                check_eq("abort_reset", 128'(prst0), 128'(1));
                check_eq("abort_response", 128'(if0.response), 128'(0));
                check_eq("abort_unstable", 128'(if0.unstable), 128'(0));
                return;
            end
            @(posedge clk); #1;
        end
        check_eq("response_held", 128'(if0.response), 128'(er));
        check_eq("unstable_held", 128'(if0.unstable), 128'(eu));
    endtask

    // Single-round instance: PRST 1, FIRE 3, SAMPLE 1, DONE at cycle 6.
    task automatic run_req1(input logic [15:0] v);
        raw1          = v;
        if1.challenge = {4{$urandom}};
        if1.start     = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_eq("t6_reset", 128'(prst1), 128'((k == 1) || (k >= 6)));
            check_eq("t6_trigger", 128'(trig1), 128'((k >= 2) && (k <= 5)));
            check_eq("t6_done", 128'(if1.done), 128'(k == 6));
            check_eq("t6_busy", 128'(if1.busy), 128'(k <= 6));
            if (k == 6) begin
                check_eq("t6_response", 128'(if1.response), 128'(v));
                check_eq("t6_unstable", 128'(if1.unstable), 128'(0));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst           = 1'b1;
        if0.start     = 1'b0;
        if1.start     = 1'b0;
        if0.challenge = '0;
        if1.challenge = '0;
        raw0          = 16'($urandom);
        raw1          = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_busy", 128'(if0.busy), 128'(0));
        check_eq("t1_done", 128'(if0.done), 128'(0));
        check_eq("t1_response", 128'(if0.response), 128'(0));
        check_eq("t1_unstable", 128'(if0.unstable), 128'(0));
        check_eq("t1_puf_reset", 128'(prst0), 128'(1));
        check_eq("t1_puf_trigger", 128'(trig0), 128'(0));
        check_eq("t1_puf_challenge", pch0, 128'(0));
        check_eq("t1_busy1", 128'(if1.busy), 128'(0));
        check_eq("t1_puf_reset1", 128'(prst1), 128'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 7; r++) pat[r] = 16'hA5C3;
        run_req0(128'h0123456789ABCDEF0123456789ABCDEF, 0, 0, 1'b1, 16'hA5C3, 16'h0000);

        pat[0] = 16'h0003; pat[1] = 16'h0003; pat[2] = 16'h0003; pat[3] = 16'h0001;
        pat[4] = 16'h0000; pat[5] = 16'h0000; pat[6] = 16'h0000;
        run_req0({4{$urandom}}, 0, 0, 1'b1, 16'h0001, 16'h0003);

        rand_pat();
        run_req0({4{$urandom}}, 40, 0, 1'b0, 16'h0, 16'h0);
        rand_pat();
        run_req0({4{$urandom}}, 92, 0, 1'b0, 16'h0, 16'h0);

        rand_pat();
        run_req0({4{$urandom}}, 0, 50, 1'b0, 16'h0, 16'h0);
        rand_pat();
        run_req0({4{$urandom}}, 0, 0, 1'b0, 16'h0, 16'h0);

        repeat (6) begin
            rand_pat();
            run_req0({4{$urandom}}, 0, 0, 1'b0, 16'h0, 16'h0);
        end

        repeat (4) run_req1(16'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
